// File: rtl/ladybird_bus_arbiter.sv
// ladybird_bus_arbiter
// Two-requester, single-outstanding arbiter. It shares one memory bus between
// the instruction-fetch port (m0) and the MMU data port (m1). All three sides
// use the req/gnt/data_gnt handshake.
//
// Ports:
//   clk, nrst                    clock, synchronous active-low reset
//   m0_* / m1_*                  requester sides: req, addr, wdata, wstrb in;
//                                gnt, data_gnt, rdata out
//   s_*                          downstream side: req, addr, wdata, wstrb out;
//                                gnt, data_gnt, rdata in
//   busy                         transaction in flight
//   owner                        current or last owner (0 = m0, 1 = m1)
//
// Build option:
//   LADYBIRD_ARB_ROUND_ROBIN_EN  when defined, a contended grant goes to the
//                                requester that is not the current owner.
//                                When undefined, m1 has fixed priority over m0.
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | no transaction in flight
// ADDR  | s_req high with latched fields, waiting for s_gnt
// DATA  | address accepted, waiting for s_data_gnt
module ladybird_bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int WSTRB_W = XLEN / 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               m0_req,
  input  logic [XLEN-1:0]    m0_addr,
  input  logic [XLEN-1:0]    m0_wdata,
  input  logic [WSTRB_W-1:0] m0_wstrb,
  output logic               m0_gnt,
  output logic               m0_data_gnt,
  output logic [XLEN-1:0]    m0_rdata,
  input  logic               m1_req,
  input  logic [XLEN-1:0]    m1_addr,
  input  logic [XLEN-1:0]    m1_wdata,
  input  logic [WSTRB_W-1:0] m1_wstrb,
  output logic               m1_gnt,
  output logic               m1_data_gnt,
  output logic [XLEN-1:0]    m1_rdata,
  output logic               s_req,
  output logic [XLEN-1:0]    s_addr,
  output logic [XLEN-1:0]    s_wdata,
  output logic [WSTRB_W-1:0] s_wstrb,
  input  logic               s_gnt,
  input  logic               s_data_gnt,
  input  logic [XLEN-1:0]    s_rdata,
  output logic               busy,
  output logic               owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
  logic               any_req;
  logic               win;
  logic               take;

  assign any_req = m0_req | m1_req;

  // Arbitration result: 1 selects m1. A lone requester always wins.
  always_comb begin
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
    win = (m0_req && m1_req) ? ~owner_q : m1_req;
`else
    win = m1_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    take    = 1'b0;
    case (state_q)
      IDLE: take = any_req;
      // s_data_gnt in ADDR is ignored: only one transaction is outstanding.
      ADDR: if (s_gnt) state_d = DATA;
      DATA: begin
        if (s_data_gnt) begin
          // Back-to-back: a pending request goes straight to ADDR.
          if (any_req) take = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = ADDR;
      owner_d = win;
      addr_d  = win ? m1_addr  : m0_addr;
      wdata_d = win ? m1_wdata : m0_wdata;
      wstrb_d = win ? m1_wstrb : m0_wstrb;
    end
  end

  always_comb begin
    s_req       = (state_q == ADDR);
    s_addr      = addr_q;
    s_wdata     = wdata_q;
    s_wstrb     = wstrb_q;
    m0_gnt      = (state_q == ADDR) && !owner_q && s_gnt;
    m1_gnt      = (state_q == ADDR) &&  owner_q && s_gnt;
    m0_data_gnt = (state_q == DATA) && !owner_q && s_data_gnt;
    m1_data_gnt = (state_q == DATA) &&  owner_q && s_data_gnt;
    m0_rdata    = ((state_q == DATA) && !owner_q) ? s_rdata : '0;
    m1_rdata    = ((state_q == DATA) &&  owner_q) ? s_rdata : '0;
    busy        = (state_q != IDLE);
    owner       = owner_q;
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
module tb_ladybird_bus_arbiter;
  logic        clk = 1'b0;
  logic        nrst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_data_gnt, m1_gnt, m1_data_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_gnt, s_data_gnt;
  logic [31:0] s_rdata;
  logic        busy, owner;

  int checks = 0;
  int errors = 0;
  int exp_order [6];

  ladybird_bus_arbiter #(.XLEN(32), .WSTRB_W(4)) dut (
    .clk(clk), .nrst(nrst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_data_gnt(m0_data_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_data_gnt(m1_data_gnt), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_gnt(s_gnt), .s_data_gnt(s_data_gnt), .s_rdata(s_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one cycle into ADDR for owner 'own'; returns at the data_gnt cycle
  // after setting the requesters' req lines to r0/r1.
  task automatic serve(input int own, input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] rd, input int dly, input logic r0, input logic r1);
    @(negedge clk); s_data_gnt = 1'b0; s_rdata = '0; #1;
    chk("srv_sreq", 32'(s_req), 32'd1);
    chk("srv_owner", 32'(owner), 32'(own));
    chk("srv_addr", s_addr, addr);
    chk("srv_wstrb", 32'(s_wstrb), 32'(wstrb));
    @(negedge clk); s_gnt = 1'b1; #1;
    chk("srv_gnt0", 32'(m0_gnt), 32'(own == 0));
    chk("srv_gnt1", 32'(m1_gnt), 32'(own == 1));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk); s_gnt = 1'b0; #1;
      chk("srv_wait_dg", 32'(m0_data_gnt | m1_data_gnt), 32'd0);
      chk("srv_wait_sreq", 32'(s_req), 32'd0);
    end
    @(negedge clk); s_gnt = 1'b0; s_data_gnt = 1'b1; s_rdata = rd;
    m0_req = r0; m1_req = r1; #1;
    chk("srv_dg0", 32'(m0_data_gnt), 32'(own == 0));
    chk("srv_dg1", 32'(m1_data_gnt), 32'(own == 1));
    chk("srv_rd0", m0_rdata, (own == 0) ? rd : 32'd0);
    chk("srv_rd1", m1_rdata, (own == 1) ? rd : 32'd0);
  endtask

  initial begin
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 1, 1};
`endif
    nrst = 1'b0;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_gnt = 0; s_data_gnt = 0; s_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    chk("rst_gnts", 32'({m0_gnt, m1_gnt, m0_data_gnt, m1_data_gnt}), 32'd0);
    @(negedge clk); nrst = 1'b1;

    // Lone fetch, data_gnt two cycles after s_gnt
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0; #1;
    chk("t1_sreq_n", 32'(s_req), 32'd0);
    serve(0, 32'h100, 4'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0);

    // Simultaneous requests: m1 first, then m0 with no IDLE bubble
    @(negedge clk); s_data_gnt = 1'b0; s_rdata = '0;
    m0_req = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h55; m1_wstrb = 4'h1; #1;
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_owner_prev", 32'(owner), 32'd0);
    serve(1, 32'h2000, 4'h1, 32'h11, 0, 1'b1, 1'b0);
    chk("t2_wdata", s_wdata, 32'h55);
    serve(0, 32'h300, 4'h0, 32'h22, 0, 1'b0, 1'b0);

    // Continuous contention after reset
    @(negedge clk); s_data_gnt = 1'b0; nrst = 1'b0;
    @(negedge clk); nrst = 1'b1; #1;
    chk("t3_owner_rst", 32'(owner), 32'd1);
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'hA0; m0_wstrb = 4'h0;
    m1_req = 1'b1; m1_addr = 32'hB0; m1_wstrb = 4'hF;
    for (int i = 0; i < 6; i++)
      serve(exp_order[i], (exp_order[i] == 1) ? 32'hB0 : 32'hA0,
            (exp_order[i] == 1) ? 4'hF : 4'h0, 32'(i + 1), 0, i < 5, i < 5);

    // Spurious responses and field change after latch
    @(negedge clk); s_data_gnt = 1'b1; s_rdata = 32'hBAD; #1;
    chk("t4_idle_dg", 32'({m0_data_gnt, m1_data_gnt}), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    @(negedge clk); s_data_gnt = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'h0; #1;
    chk("t4_idle_busy2", 32'(busy), 32'd0);
    @(negedge clk); s_data_gnt = 1'b1; m0_addr = 32'h80; #1;
    chk("t4_addr_dg", 32'({m0_data_gnt, m1_data_gnt, m0_gnt, m1_gnt}), 32'd0);
    chk("t6_saddr0", s_addr, 32'h40);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); s_data_gnt = 1'b0; #1;
      chk("t6_sreq", 32'(s_req), 32'd1);
      chk("t6_saddr", s_addr, 32'h40);
    end
    @(negedge clk); s_gnt = 1'b1; s_data_gnt = 1'b1; #1;
    chk("t4_both_gnt", 32'(m0_gnt), 32'd1);
    chk("t4_both_dg", 32'(m0_data_gnt), 32'd0);
    @(negedge clk); s_gnt = 1'b1; s_data_gnt = 1'b0; m0_req = 1'b0; #1;
    chk("t4_data_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    chk("t4_data_sreq", 32'(s_req), 32'd0);
    @(negedge clk); s_gnt = 1'b0; #1;
    chk("t4_still_data", 32'(busy), 32'd1);
    chk("t4_still_sreq", 32'(s_req), 32'd0);
    @(negedge clk); s_data_gnt = 1'b1; s_rdata = 32'h1234; #1;
    chk("t4_dg", 32'(m0_data_gnt), 32'd1);
    chk("t4_rd", m0_rdata, 32'h1234);
    @(negedge clk); s_data_gnt = 1'b0; s_rdata = '0; #1;
    chk("t4_idle_end", 32'(busy), 32'd0);

    // Reset mid-DATA, late response dropped
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h500;
    @(negedge clk); s_gnt = 1'b1; #1;
    chk("t5_gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk); s_gnt = 1'b0; m0_req = 1'b0; #1;
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_owner", 32'(owner), 32'd0);
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1; s_data_gnt = 1'b1; s_rdata = 32'h77; #1;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_owner_rst", 32'(owner), 32'd1);
    chk("t5_dg", 32'({m0_data_gnt, m1_data_gnt}), 32'd0);
    chk("t5_rd", m0_rdata | m1_rdata, 32'd0);
    @(negedge clk); s_data_gnt = 1'b0; #1;
    chk("t5_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
